// File: rtl/sync_frame_tx.sv
// sync_frame_tx
//   Serial frame transmitter. Each accepted parallel word goes out on a
//   1-bit line as one frame: a fixed sync preamble (MSB-first), the payload
//   (MSB-first), an optional even-parity bit, then GAP_LEN forced-0 cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low (0 = reset)
//   in_data      payload word, sampled only on handshake
//   in_valid     upstream has a word
//   in_ready     block can accept a word (IDLE and out of reset)
//   out          registered serial line
//   busy         high while a frame is in progress
//   frame_start  one-cycle pulse in the first preamble bit cycle
module sync_frame_tx #(
    parameter int unsigned DATA_W    = 8,
    parameter logic [15:0] SYNC_PAT  = 16'b1101,
    parameter int unsigned SYNC_LEN  = 4,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              frame_start
);

    localparam int unsigned MAX_SD  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int unsigned MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
    localparam int unsigned CW      = $clog2(MAX_LEN + 1);
    // Index of the second preamble bit; clamped so SYNC_LEN=1 still elaborates.
    localparam int unsigned SYNC_TOP = (SYNC_LEN >= 2) ? SYNC_LEN - 2 : 0;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SYNC = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] PAR  = 3'd3;
    localparam logic [2:0] GAP  = 3'd4;

    logic [2:0]        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              parity, parity_n;
    logic              out_n;
    logic              fs_n;
    logic [3:0]        sync_idx;
    logic              handshake;

    // Reset gates in_ready combinationally so nothing is accepted while held.
    assign in_ready  = rst && (state == IDLE);
    assign handshake = in_valid && in_ready;
    assign busy      = (state == SYNC) || (state == DATA) ||
                       (state == PAR)  || (state == GAP);

    // out is registered, so each branch loads the bit for the *next* cycle:
    // the state names what is currently on the line, cnt its position.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        parity_n = parity;
        out_n    = 1'b0;
        fs_n     = 1'b0;
        sync_idx = 4'(SYNC_TOP) - 4'(cnt);
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_n  = SYNC;
                    cnt_n    = '0;
                    shreg_n  = in_data;
                    parity_n = 1'b0;
                    out_n    = SYNC_PAT[4'(SYNC_LEN - 1)];
                    fs_n     = 1'b1;
                end
            end
            SYNC: begin
                if (cnt == CW'(SYNC_LEN - 1)) begin
                    state_n  = DATA;
                    cnt_n    = '0;
                    out_n    = shreg[DATA_W-1];
                    parity_n = shreg[DATA_W-1];
                    shreg_n  = shreg << 1;
                end else begin
                    cnt_n = cnt + 1'b1;
                    out_n = SYNC_PAT[sync_idx];
                end
            end
            DATA: begin
                if (cnt == CW'(DATA_W - 1)) begin
                    cnt_n = '0;
                    if (PARITY_EN != 0) begin
                        state_n = PAR;
                        out_n   = parity;
                    end else begin
                        state_n = GAP;
                    end
                end else begin
                    cnt_n    = cnt + 1'b1;
                    out_n    = shreg[DATA_W-1];
                    parity_n = parity ^ shreg[DATA_W-1];
                    shreg_n  = shreg << 1;
                end
            end
            PAR: begin
                state_n = GAP;
                cnt_n   = '0;
            end
            GAP: begin
                if (cnt == CW'(GAP_LEN - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            out         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            parity      <= parity_n;
            out         <= out_n;
            frame_start <= fs_n;
        end
    end

endmodule
